// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the parameterised serial sequence detector.
// Optional match counter is enabled with `define SEQ_DET_CNT_EN.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 32;
  localparam int unsigned LEN_W     = $clog2(MAX_PAT_W + 1);

  typedef logic [LEN_W-1:0] len_t;

  localparam logic [MAX_PAT_W-1:0] RST_PAT = 32'h0000_000B;
  localparam len_t                 RST_LEN = len_t'(4);

  // Oversized lengths collapse to the full history width.
  function automatic len_t clamp_len(input len_t len, input int unsigned pat_w);
    return (32'(len) > pat_w) ? len_t'(pat_w) : len;
  endfunction

endpackage

// File: rtl/param_seq_detector_if.sv
// Link between the detector datapath and its masked pattern comparator.
interface param_seq_detector_if
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8
) ();

  logic [PAT_W-1:0] hist_next;
  logic [PAT_W-1:0] pat;
  len_t             len;
  logic             hit;

  modport master (output hist_next, output pat, output len, input hit);
  modport slave  (input hist_next, input pat, input len, output hit);

endinterface

// File: rtl/seq_det_cmp.sv
// Combinational compare of the low len bits of the next history against the pattern.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8
) (
  param_seq_detector_if.slave cmp_if
);

  logic [PAT_W-1:0] mask_c;

  always_comb begin
    mask_c = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (i < 32'(cmp_if.len));
    end
  end

  // A zero-length pattern never matches, even though its mask is empty.
  assign cmp_if.hit = (cmp_if.len != '0) &&
                      (((cmp_if.hist_next ^ cmp_if.pat) & mask_c) == '0);

endmodule

// File: rtl/param_seq_detector.sv
// Serial pattern detector with runtime pattern/length/overlap config and a match pulse.
// `define SEQ_DET_CNT_EN adds the saturating match counter and its clear input.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         din,
  input  logic                         din_vld,
  input  logic                         cfg_load,
  input  logic [PAT_W-1:0]             cfg_pat,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic                         cfg_ovl,
  input  logic                         cnt_clr,
  output logic                         dout,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam logic [PAT_W-1:0] RST_PAT_P = RST_PAT[PAT_W-1:0];
  localparam len_t             RST_LEN_P = clamp_len(RST_LEN, PAT_W);
  localparam len_t             FULL_LEN  = len_t'(PAT_W);

  logic [PAT_W-1:0] hist_q, hist_d;
  len_t             fill_q, fill_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  len_t             len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             dout_q, dout_d;

  logic [PAT_W-1:0] hist_nx;
  len_t             fill_nx;
  logic             hit;
  logic             match_c;

  param_seq_detector_if #(.PAT_W(PAT_W)) cmp_if ();

  assign cmp_if.hist_next = hist_nx;
  assign cmp_if.pat       = pat_q;
  assign cmp_if.len       = len_q;
  assign hit              = cmp_if.hit;

  seq_det_cmp #(.PAT_W(PAT_W)) u_cmp (
    .cmp_if (cmp_if.slave)
  );

  // Next-state: config load takes priority and swallows any same-cycle sample.
  always_comb begin
    hist_nx = {hist_q[PAT_W-2:0], din};
    fill_nx = (fill_q == FULL_LEN) ? fill_q : fill_q + len_t'(1);
    match_c = din_vld && !cfg_load && (fill_nx >= len_q) && hit;

    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    dout_d  = match_c;

    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = clamp_len(len_t'(cfg_len), PAT_W);
      ovl_d  = cfg_ovl;
      hist_d = '0;
      fill_d = '0;
    end else if (din_vld) begin
      hist_d = hist_nx;
      // Non-overlapping mode demands len fresh bits after every match.
      fill_d = (match_c && !ovl_q) ? '0 : fill_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PAT_P;
      len_q  <= RST_LEN_P;
      ovl_q  <= 1'b1;
      dout_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_W-1];

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a coincident match; count saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed, table-driven bench for param_seq_detector (PAT_W=8, CNT_W=2).
module tb_param_seq_detector;
  import seq_det_pkg::*;

  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 2;
`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             din      = 1'b0;
  logic             din_vld  = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pat  = '0;
  logic [3:0]       cfg_len  = '0;
  logic             cfg_ovl  = 1'b0;
  logic             cnt_clr  = 1'b0;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;

  typedef struct packed {
    logic vld;
    logic d;
    logic clr;
    logic exp;
  } vec_t;

  vec_t tbl [0:63];
  int   tidx     = 0;
  int   checks   = 0;
  int   failures = 0;

  param_seq_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cnt_clr   (cnt_clr),
    .dout      (dout),
    .match_cnt (match_cnt)
  );

  param_seq_detector_if #(.PAT_W(PAT_W)) cmp_bus ();
  seq_det_cmp #(.PAT_W(PAT_W)) u_cmp (.cmp_if(cmp_bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int unsigned v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  // Streams are written MSB first: bit n-1 is the first cycle.
  task automatic add_stream(input int n, input logic [15:0] bits, input logic [15:0] vlds,
                            input logic [15:0] exps, output int lo);
    lo = tidx;
    for (int k = n - 1; k >= 0; k--) begin
      tbl[tidx] = '{vld: vlds[k], d: bits[k], clr: 1'b0, exp: exps[k]};
      tidx++;
    end
  endtask

  task automatic cyc(input logic vld, input logic d, input logic clr);
    din_vld = vld;
    din     = d;
    cnt_clr = clr;
    @(posedge clk);
    @(negedge clk);
    din_vld = 1'b0;
    cnt_clr = 1'b0;
  endtask

  task automatic run_seg(input string name, input int lo, input int n);
    for (int i = lo; i < lo + n; i++) begin
      cyc(tbl[i].vld, tbl[i].d, tbl[i].clr);
      check($sformatf("%s[%0d]", name, i - lo), 32'(dout), 32'(tbl[i].exp));
    end
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic vld, input logic d);
    cfg_pat  = p;
    cfg_len  = l;
    cfg_ovl  = o;
    cfg_load = 1'b1;
    din_vld  = vld;
    din      = d;
    @(posedge clk);
    @(negedge clk);
    cfg_load = 1'b0;
    din_vld  = 1'b0;
    check("load_dout", 32'(dout), 32'd0);
  endtask

  task automatic cmp_vec(input string name, input logic [7:0] h, input logic [7:0] p,
                         input int unsigned l, input logic exp);
    cmp_bus.hist_next = h;
    cmp_bus.pat       = p;
    cmp_bus.len       = len_t'(l);
    #1;
    check(name, 32'(cmp_bus.hit), 32'(exp));
  endtask

  initial begin
    int a_lo, b_lo, c_lo, d_lo, e_lo, f_lo, g_lo;
    add_stream(7,  16'b1011011,       16'hFFFF,          16'b0001001,       a_lo);
    add_stream(7,  16'b1011011,       16'hFFFF,          16'b0001000,       b_lo);
    add_stream(13, 16'b1101100010110, 16'b1011001111010, 16'b0000000000010, c_lo);
    add_stream(6,  16'b111111,        16'hFFFF,          16'b011111,        d_lo);
    add_stream(7,  16'b0111011,       16'hFFFF,          16'b0000001,       e_lo);
    add_stream(8,  16'b10110000,      16'hFFFF,          16'b00000000,      f_lo);
    add_stream(8,  16'b10100101,      16'hFFFF,          16'b00000001,      g_lo);

    // Reset defaults
    @(negedge clk);
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;

    // Default config 1011, overlapping
    run_seg("ovl_dflt", a_lo, 7);
    check("cnt_ovl", 32'(match_cnt), ecnt(2));

    // Non-overlapping, counter survives load then cleared
    load(8'h0B, 4'd4, 1'b0, 1'b0, 1'b0);
    check("cnt_after_load", 32'(match_cnt), ecnt(2));
    cyc(1'b0, 1'b0, 1'b1);
    check("cnt_clr", 32'(match_cnt), 32'd0);
    run_seg("novl", b_lo, 7);
    check("cnt_novl", 32'(match_cnt), ecnt(1));

    // 8-bit pattern with valid gaps
    load(8'hA5, 4'd8, 1'b1, 1'b0, 1'b0);
    run_seg("gaps", c_lo, 13);
    check("cnt_gaps", 32'(match_cnt), ecnt(2));

    // Saturation and clear-vs-match priority
    cyc(1'b0, 1'b0, 1'b1);
    load(8'h03, 4'd2, 1'b1, 1'b0, 1'b0);
    run_seg("sat", d_lo, 6);
    check("cnt_sat", 32'(match_cnt), ecnt(3));
    cyc(1'b1, 1'b1, 1'b1);
    check("clr_match_dout", 32'(dout), 32'd1);
    check("clr_match_cnt", 32'(match_cnt), 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check("post_clr_dout", 32'(dout), 32'd1);
    check("post_clr_cnt", 32'(match_cnt), ecnt(1));

    // Reset mid-pattern: first 3 bits of 1011 are discarded
    cyc(1'b1, 1'b0, 1'b0); check("pre_rst0", 32'(dout), 32'd0);
    cyc(1'b1, 1'b1, 1'b0); check("pre_rst1", 32'(dout), 32'd0);
    cyc(1'b1, 1'b0, 1'b0); check("pre_rst2", 32'(dout), 32'd0);
    cyc(1'b1, 1'b1, 1'b0); check("pre_rst3", 32'(dout), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout", 32'(dout), 32'd0);
    check("async_rst_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b0); check("post_rst_4th", 32'(dout), 32'd0);
    cyc(1'b1, 1'b0, 1'b0); check("post_rst_b1", 32'(dout), 32'd0);
    cyc(1'b1, 1'b1, 1'b0); check("post_rst_b2", 32'(dout), 32'd0);
    cyc(1'b1, 1'b1, 1'b0); check("post_rst_dflt", 32'(dout), 32'd1);
    check("post_rst_cnt", 32'(match_cnt), ecnt(1));

    // Load with a completing sample in the same cycle: sample dropped
    cyc(1'b1, 1'b0, 1'b0); check("pre_ld0", 32'(dout), 32'd0);
    cyc(1'b1, 1'b1, 1'b0); check("pre_ld1", 32'(dout), 32'd0);
    load(8'h0B, 4'd4, 1'b1, 1'b1, 1'b1);
    run_seg("ld_drop", e_lo, 7);

    // len=0 never matches; len beyond PAT_W behaves as PAT_W
    load(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
    run_seg("len0", f_lo, 8);
    load(8'hA5, 4'd11, 1'b1, 1'b0, 1'b0);
    run_seg("len_clamp", g_lo, 8);

    // Direct comparator vectors
    cmp_vec("cmp_len4", 8'h3B, 8'h0B, 4, 1'b1);
    cmp_vec("cmp_len2", 8'hF3, 8'h03, 2, 1'b1);
    cmp_vec("cmp_len0", 8'h00, 8'h00, 0, 1'b0);
    cmp_vec("cmp_len8_miss", 8'hA5, 8'hA4, 8, 1'b0);
    cmp_vec("cmp_len7_hit", 8'h25, 8'hA5, 7, 1'b1);
    cmp_vec("cmp_len8_msb", 8'h25, 8'hA5, 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
